axis_frame_fifo: RTL

Native AXI-Stream frame FIFO for the shell-side stream datapath, superseding the fixed-configuration frame-mode FIFO wrapper. It stores complete frames in on-chip RAM and releases a frame to the master side only after its tlast beat is committed. Parameters select depth, width and drop policy. Mid-frame rollback, bad-frame drop, drop-when-full and live frame/occupancy counters are built in.

---
 rtl/axis_frame_fifo_pkg.sv | 10 +
 rtl/axis_frame_fifo_ram.sv | 20 ++
 rtl/axis_frame_fifo.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/axis_frame_fifo_pkg.sv
// Shared types and helpers for the AXI-Stream frame FIFO.
package axis_frame_fifo_pkg;
  typedef enum logic {WR_ACCEPT = 1'b0, WR_DROP = 1'b1} wr_state_e;

  // Bad-frame match: only the masked tuser bits of the tlast beat take part.
  function automatic logic is_bad_frame(input logic [31:0] tuser, input logic [31:0] value,
                                        input logic [31:0] mask);
    return ((tuser ^ value) & mask) == 32'd0;
  endfunction
endpackage

// File: rtl/axis_frame_fifo_ram.sv
// Simple dual-port beat RAM with registered read port; contents are not reset.
module axis_frame_fifo_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int WIDTH      = 38
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);
  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/axis_frame_fifo.sv
// Store-and-forward AXI-Stream FIFO: frames become visible on m_axis only once
// their tlast beat is committed; supports bad-frame drop and drop-when-full.
module axis_frame_fifo
  import axis_frame_fifo_pkg::*;
#(
  parameter int                    ADDR_WIDTH           = 10,
  parameter int                    DATA_WIDTH           = 32,
  parameter int                    KEEP_WIDTH           = DATA_WIDTH / 8,
  parameter int                    USER_WIDTH           = 1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK  = 1'b1,
  parameter int                    DROP_BAD_FRAME       = 0,
  parameter int                    DROP_WHEN_FULL       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  status_overflow,
  output logic                  status_bad_frame,
  output logic                  status_good_frame,
  output logic                  status_empty,
  output logic [ADDR_WIDTH:0]   status_frame_count,
  output logic [ADDR_WIDTH:0]   status_occupancy
);
  localparam int                  RAM_W = KEEP_WIDTH + DATA_WIDTH + USER_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic                DWF   = (DROP_WHEN_FULL != 0);
  localparam logic                DBF   = (DROP_BAD_FRAME != 0);

  wr_state_e           state, state_n;
  logic [ADDR_WIDTH:0] wr_cur, wr_cur_n, wr_commit, wr_commit_n, rd, rd_n, frame_count_n;
  logic                full, s_hs, beat_bad, drop_full, ram_we, commit;
  logic                load, m_hs, m_valid_n, good_n, bad_n, ovf_n;
  logic [RAM_W-1:0]    ram_q;

  assign full          = (wr_cur - rd) == DEPTH;
  assign s_axis_tready = !rst && (DWF || !full || state == WR_DROP);
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign beat_bad      = is_bad_frame(32'(s_axis_tuser), 32'(USER_BAD_FRAME_VALUE),
                                      32'(USER_BAD_FRAME_MASK));
  // No room for this beat and none coming: either dropping is allowed, or the
  // frame alone already fills the RAM and could never commit.
  assign drop_full     = s_axis_tvalid && full && (DWF || wr_commit == rd);

  always_ff @(posedge clk) begin
    if (rst) state <= WR_ACCEPT;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      WR_ACCEPT: if (drop_full && !s_axis_tlast) state_n = WR_DROP;
      WR_DROP:   if (s_hs && s_axis_tlast)       state_n = WR_ACCEPT;
      default:   state_n = WR_ACCEPT;
    endcase
  end

  always_comb begin
    ram_we      = 1'b0;
    wr_cur_n    = wr_cur;
    wr_commit_n = wr_commit;
    commit      = 1'b0;
    good_n      = 1'b0;
    bad_n       = 1'b0;
    ovf_n       = 1'b0;
    case (state)
      WR_ACCEPT: begin
        if (drop_full) begin
          if (!s_axis_tlast) begin
            wr_cur_n = wr_commit;
          end else if (DWF) begin
            wr_cur_n = wr_commit;
            ovf_n    = 1'b1;
          end
        end else if (s_hs) begin
          ram_we   = 1'b1;
          wr_cur_n = wr_cur + 1'b1;
          if (s_axis_tlast) begin
            if (beat_bad && DBF) begin
              wr_cur_n = wr_commit;
              bad_n    = 1'b1;
            end else begin
              wr_commit_n = wr_cur + 1'b1;
              commit      = 1'b1;
              good_n      = !beat_bad;
              bad_n       = beat_bad;
            end
          end
        end
      end
      WR_DROP: if (s_hs && s_axis_tlast) ovf_n = 1'b1;
      default: ;
    endcase
  end

  axis_frame_fifo_ram #(.ADDR_WIDTH(ADDR_WIDTH), .WIDTH(RAM_W)) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (wr_cur[ADDR_WIDTH-1:0]),
    .wr_data ({s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata}),
    .rd_en   (load),
    .rd_addr (rd[ADDR_WIDTH-1:0]),
    .rd_data (ram_q)
  );

  assign load      = (wr_commit != rd) && (!m_axis_tvalid || m_axis_tready);
  assign m_hs      = m_axis_tvalid && m_axis_tready;
  assign rd_n      = load ? rd + 1'b1 : rd;
  assign m_valid_n = load || (m_axis_tvalid && !m_axis_tready);

  // The RAM read register is the output register; gating by tvalid gives the
  // cleared payload after reset and between beats.
  assign m_axis_tdata = m_axis_tvalid ? ram_q[DATA_WIDTH-1:0] : '0;
  assign m_axis_tkeep = m_axis_tvalid ? ram_q[DATA_WIDTH +: KEEP_WIDTH] : '0;
  assign m_axis_tuser = m_axis_tvalid ? ram_q[DATA_WIDTH+KEEP_WIDTH +: USER_WIDTH] : '0;
  assign m_axis_tlast = m_axis_tvalid && ram_q[RAM_W-1];

  always_comb begin
    frame_count_n = status_frame_count;
    if (commit && !(m_hs && m_axis_tlast))      frame_count_n = status_frame_count + 1'b1;
    else if (!commit && m_hs && m_axis_tlast)   frame_count_n = status_frame_count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cur             <= '0;
      wr_commit          <= '0;
      rd                 <= '0;
      m_axis_tvalid      <= 1'b0;
      status_overflow    <= 1'b0;
      status_bad_frame   <= 1'b0;
      status_good_frame  <= 1'b0;
      status_empty       <= 1'b1;
      status_frame_count <= '0;
      status_occupancy   <= '0;
    end else begin
      wr_cur             <= wr_cur_n;
      wr_commit          <= wr_commit_n;
      rd                 <= rd_n;
      m_axis_tvalid      <= m_valid_n;
      status_overflow    <= ovf_n;
      status_bad_frame   <= bad_n;
      status_good_frame  <= good_n;
      status_empty       <= (wr_commit_n == rd_n) && !m_valid_n;
      status_frame_count <= frame_count_n;
      status_occupancy   <= wr_cur_n - rd_n;
    end
  end
endmodule
